// File: rtl/adc_sched_pkg.sv
// adc_sched_pkg: shared state encoding, widths and helpers for the ADC capture scheduler
package adc_sched_pkg;
  typedef enum logic [2:0] {IDLE, ARM, WAIT_END, SEL, READ, DONE} state_t;
  localparam int N_CH_DEF = 4;
  localparam int CH_W = $clog2(N_CH_DEF);
  localparam int UNDERRUN_LIM = 16;
  function automatic logic [4:0] first_set(input logic [31:0] m);
    first_set = '0;
    for (int i = 31; i >= 0; i--) if (m[i]) first_set = 5'(i);
  endfunction
endpackage

// File: rtl/adc_fifo_rd_port.sv
// adc_fifo_rd_port: one-outstanding FIFO read and valid/ready output register for the selected channel
module adc_fifo_rd_port #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          en,
  input  logic          empty,
  input  logic          last,
  input  logic [DW-1:0] q,
  input  logic          out_ready,
  output logic          rdreq,
  output logic          pend,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          out_last
);
  // a new read is only launched when the output register is free by the time q arrives
  assign rdreq = en && !empty && !pend && (!out_valid || out_ready);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      pend      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      pend <= rdreq;
      if (pend) begin
        out_data  <= q;
        out_valid <= 1'b1;
        out_last  <= last;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
endmodule

// File: rtl/adc_capture_scheduler.sv
// adc_capture_scheduler: arms enabled ADC channels, waits for completion, drains FIFOs in channel order
module adc_capture_scheduler
  import adc_sched_pkg::*;
#(
  parameter int N_CH    = N_CH_DEF,
  parameter int DW      = 8,
  parameter int SAMPLES = 4096,
  parameter int TIMEOUT = 1 << 24,
  parameter int MIN_LOW = 4
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [N_CH-1:0]         ch_mask,
  output logic [N_CH-1:0]         ADC_bg,
  input  logic [N_CH-1:0]         ADC_end,
  input  logic [N_CH-1:0]         fifo_empty,
  input  logic [N_CH*DW-1:0]      fifo_q,
  output logic [N_CH-1:0]         fifo_rdreq,
  output logic [DW-1:0]           out_data,
  output logic [$clog2(N_CH)-1:0] out_ch,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output logic                    err_timeout,
  output logic                    err_underrun
);
  localparam int CW = $clog2(N_CH);
  localparam int SW = $clog2(SAMPLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(MIN_LOW + 1);
  localparam logic [SW-1:0] S_ALL  = SW'(SAMPLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] G_MIN  = GW'(MIN_LOW);
  localparam logic [4:0]    U_LIM  = 5'(UNDERRUN_LIM);
  state_t          state;
  logic [N_CH-1:0] rem;
  logic [CW-1:0]   ch;
  logic [SW-1:0]   cnt;
  logic [TW-1:0]   tcnt;
  logic [GW-1:0]   gap;
  logic [4:0]      ucnt;
  logic            rdreq, pend, kill, hs, leave, stall;
  assign kill  = abort && state != IDLE;
  assign hs    = out_valid && out_ready;
  // an underrun only retires the channel once the word already in the output register is taken
  assign leave = state == READ && ((hs && out_last) || (ucnt == U_LIM && !out_valid));
  assign stall = fifo_empty[ch] && !pend && cnt < S_ALL;
  assign fifo_rdreq = N_CH'(rdreq) << ch;
  assign out_ch = ch;
  adc_fifo_rd_port #(.DW(DW)) u_port (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .flush    (kill),
    .en       (state == READ && cnt < S_ALL && !abort && !leave),
    .empty    (fifo_empty[ch]),
    .last     (cnt == S_ALL),
    .q        (fifo_q[ch*DW +: DW]),
    .out_ready(out_ready),
    .rdreq    (rdreq),
    .pend     (pend),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_last (out_last)
  );
  // gap counts cycles with ADC_bg low and saturates at MIN_LOW, which is when a new start may arm
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state        <= IDLE;
      rem          <= '0;
      ch           <= '0;
      cnt          <= '0;
      tcnt         <= '0;
      gap          <= G_MIN;
      ucnt         <= '0;
      ADC_bg       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_timeout  <= 1'b0;
      err_underrun <= 1'b0;
    end else if (kill) begin
      state  <= IDLE;
      ADC_bg <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      gap    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (gap != G_MIN) gap <= gap + 1'b1;
          if (start && gap == G_MIN) begin
            rem          <= ch_mask;
            busy         <= 1'b1;
            err_timeout  <= 1'b0;
            err_underrun <= 1'b0;
            state        <= ch_mask == '0 ? DONE : ARM;
          end
        end
        ARM: begin
          ADC_bg <= rem;
          tcnt   <= '0;
          state  <= WAIT_END;
        end
        WAIT_END:
          if ((ADC_end & rem) == rem) state <= SEL;
          else if (tcnt == T_LAST) begin
            err_timeout <= 1'b1;
            ADC_bg      <= '0;
            gap         <= '0;
            busy        <= 1'b0;
            state       <= IDLE;
          end else tcnt <= tcnt + 1'b1;
        SEL:
          if (rem == '0) state <= DONE;
          else begin
            ch    <= CW'(first_set(32'(rem)));
            cnt   <= '0;
            ucnt  <= '0;
            state <= READ;
          end
        READ: begin
          if (rdreq) cnt <= cnt + 1'b1;
          ucnt <= stall ? (ucnt == U_LIM ? U_LIM : ucnt + 1'b1) : '0;
          if (leave) begin
            rem[ch]      <= 1'b0;
            err_underrun <= err_underrun || !(hs && out_last);
            state        <= SEL;
          end
        end
        DONE: begin
          if (|ADC_bg) gap <= '0;
          ADC_bg <= '0;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
